// File: rtl/uart_core_if.sv
// uart_core_if: fabric-side handshake bundle for uart_core.
//   tx_data/tx_valid/tx_ready  : word to transmit, valid/ready handshake
//   rx_data/rx_valid/rx_ready  : head received word, show-ahead valid/ready
//   rx_frame_err/rx_parity_err : flags travelling with the head word
//   rx_overrun                 : sticky, a received word was dropped
// master = user logic, slave = uart_core.
interface uart_core_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART (5..9 data bits, none/odd/even
// parity, 1 or 2 TX stop bits) with valid/ready handshakes and an RX buffer.
// Ports:
//   clk     : system clock, rising edge
//   btn     : asynchronous active-low reset
//   uart_rx : serial input (asynchronous, idle high)
//   uart_tx : serial output (idle high)
//   led     : ~low 6 bits of the last received word (active-low LEDs)
//   bus     : uart_core_if.slave handshake bundle
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO;
// otherwise the RX buffer is a single holding register.
module uart_core #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        btn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [5:0]  led,
  uart_core_if.slave  bus
);

`ifdef UART_RX_FIFO_EN
  localparam int unsigned DEPTH = FIFO_DEPTH;
`else
  // Single holding register; FIFO_DEPTH has no effect in this build.
  localparam int unsigned DEPTH = (FIFO_DEPTH != 0) ? 1 : 1;
`endif

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 frame_err;
    logic                 parity_err;
  } rx_entry_t;

  // ---------------------------------------------------------------- RX sync
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_push_c, rx_ferr_c;

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // Sampling points are all CLKS_PER_BIT apart, anchored on the start midpoint.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          // Line high again at the midpoint: glitch, no frame.
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_BIT) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == CNT_BIT) begin
          rx_cnt_d   = '0;
          rx_perr_d  = sync2_q != ((^rx_shift_q) ^ ODD_PAR);
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_BIT) begin
          rx_push_c  = 1'b1;
          rx_ferr_c  = !sync2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX buffer
  // Shift-down FIFO: entry 0 is always the head, so outputs come from flops.
  rx_entry_t         fifo_q [DEPTH];
  rx_entry_t         fifo_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic              overrun_q, overrun_d;
  logic [5:0]        led_q, led_d;
  rx_entry_t         push_entry_c;
  logic              pop_c, full_c, placed_c;

  always_comb begin
    fifo_d       = fifo_q;
    vld_d        = vld_q;
    overrun_d    = overrun_q;
    led_d        = led_q;
    placed_c     = 1'b0;
    pop_c        = vld_q[0] && bus.rx_ready;
    full_c       = vld_q[DEPTH-1];
    push_entry_c = '{data: rx_shift_q, frame_err: rx_ferr_c, parity_err: rx_perr_q};
    if (pop_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
      overrun_d      = 1'b0;
    end
    if (rx_push_c) begin
      led_d = ~6'(rx_shift_q);
      if (full_c && !pop_c) begin
        overrun_d = 1'b1;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (!placed_c && !vld_d[i]) begin
            fifo_d[i] = push_entry_c;
            vld_d[i]  = 1'b1;
            placed_c  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      vld_q     <= '0;
      overrun_q <= 1'b0;
      led_q     <= 6'h3F;
    end else begin
      fifo_q    <= fifo_d;
      vld_q     <= vld_d;
      overrun_q <= overrun_d;
      led_q     <= led_d;
    end
  end

  assign bus.rx_valid      = vld_q[0];
  assign bus.rx_data       = fifo_q[0].data;
  assign bus.rx_frame_err  = fifo_q[0].frame_err;
  assign bus.rx_parity_err = fifo_q[0].parity_err;
  assign bus.rx_overrun    = overrun_q;
  assign led               = led_q;

  // ---------------------------------------------------------------- TX FSM
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // tx_d is the line value for the next cycle, so uart_tx is a clean flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_shift_d = bus.tx_data;
          tx_par_d   = (^bus.tx_data) ^ ODD_PAR;
          tx_d       = 1'b0;
          tx_ready_d = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_BIT) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_BIT) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            if (HAS_PAR) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == CNT_BIT) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_STOP) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_ready_d = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  assign uart_tx      = tx_q;
  assign bus.tx_ready = tx_ready_q;

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART transceiver, successor to the fixed-format `uart` top. It receives and transmits frames of 5–9 data bits with optional odd/even parity and 1 or 2 stop bits. Valid/ready handshakes face the fabric on both directions, and an optional RX FIFO buffers received words. It sits between the board pins `uart_rx`/`uart_tx` and user logic; `led` shows the last received word for bring-up.

## Interface
- `CLKS_PER_BIT`, 8: clocks per bit period; must be ≥4 and even.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2; applies to TX only.
- `FIFO_DEPTH`, 4: RX FIFO entries, power of two ≥2.

- `clk` in 1: system clock, all logic on rising edge.
- `btn` in 1: reset, asynchronous, active-low.
- `uart_rx` in 1: serial input, asynchronous, idle high.
- `uart_tx` out 1: serial output, idle high.
- `tx_data` in DATA_BITS: word to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: transmitter accepts a word.
- `rx_data` out DATA_BITS: head received word.
- `rx_valid` out 1: `rx_data` and its error flags are valid.
- `rx_ready` in 1: consumer pops the head word.
- `rx_frame_err` out 1: head word's stop bit sampled 0.
- `rx_parity_err` out 1: head word's parity mismatched; always 0 when PARITY=0.
- `rx_overrun` out 1: sticky; a received word was dropped.
- `led` out 6: `~` (low 6 bits of last received word), for active-low LEDs.

## Operation
- Reset values:
  - `uart_tx`=1, `tx_ready`=1.
  - `rx_valid`=0, `rx_data`=0, both error flags 0, `rx_overrun`=0.
  - `led`=6'h3F.
  - FIFO empty, both FSMs IDLE, sync flops 1.
- RX input passes through a 2-flop synchroniser; the FSM sees only the synchronised line.
- RX FSM, IDLE→START→DATA→(PARITY)→STOP→IDLE:
  - IDLE: a synchronised 0 enters START and clears the bit counter.
  - START: at count CLKS_PER_BIT/2−1, resample. If the line is 0, go to DATA. If it is 1, it was a glitch: back to IDLE, no word.
  - DATA: sample every CLKS_PER_BIT cycles from the start midpoint, LSB first, DATA_BITS samples.
  - PARITY (when PARITY≠0): one sample; mismatch sets the word's parity flag.
  - STOP: one sample. A 0 sets the word's frame flag. Push {word, flags} and return to IDLE in the same cycle, so a new start edge is accepted immediately. A second stop bit is not checked.
- Push and pop:
  - Pop occurs on `rx_valid && rx_ready`. FIFO is show-ahead; flags travel with their word.
  - Push when FIFO full and no pop that cycle: drop the new word, set `rx_overrun`. `rx_overrun` clears on the next pop.
  - Push and pop in the same cycle when full: both succeed, no overrun.
- `led` updates on every push, dropped words included.
- TX FSM, IDLE→START→DATA→(PARITY)→STOP→IDLE:
  - Accept on `tx_valid && tx_ready`; the word is latched and `tx_ready` drops the next cycle.
  - Each state lasts CLKS_PER_BIT cycles; STOP lasts STOP_BITS×CLKS_PER_BIT.
  - Parity bit = XOR of data, inverted for odd.
- Asserting `btn` mid-frame returns everything to reset values asynchronously, including `uart_tx`=1 with no glitch low. A partial RX frame is discarded.

## Timing
- RX: `rx_valid` rises 1 cycle after the stop-bit midpoint sample (push registered). No empty-FIFO bypass.
- RX: start-edge-to-`rx_valid` equals 2 (sync) + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)·CLKS_PER_BIT + 1 cycles.
  - P = 1 when PARITY≠0, else 0.
- TX: `uart_tx` falls in the cycle after acceptance.
- TX: `tx_ready` rises the cycle after the last stop cycle. Total busy time is (1 + DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT cycles.
- All outputs are registered.

## Configuration
- `UART_RX_FIFO_EN` defined: RX buffer is a FIFO of FIFO_DEPTH entries.
- `UART_RX_FIFO_EN` undefined: RX buffer is a single holding register (depth 1) and FIFO_DEPTH is ignored. Same push, pop and overrun rules apply at depth 1.

## Test plan
- Default config (8N1, CLKS_PER_BIT=8). Drive bits 1,0,1,1,0,0,1,0 after the start bit, then stop=1. Required: `rx_valid`=1, `rx_data`=8'h4D, both error flags 0, `led`=6'h32.
- Glitch rejection: pull `uart_rx` low for 3 cycles, then high. Required: FSM back in IDLE, no push, `rx_valid` stays 0.
- Framing error: send 0x4D with stop=0, then idle. Required: word 8'h4D with `rx_frame_err`=1. The next clean frame 0x12 arrives with flag 0.
- Parity check: set PARITY=2, send 0x4D with parity bit 1. Required: `rx_parity_err`=1. Resend with parity bit 0. Required: `rx_parity_err`=0.
- Overrun: hold `rx_ready`=0 and send 0x01..0x05 (depth 4). Required: 0x01..0x04 pop in order and `rx_overrun`=1; it clears on the first pop. With `UART_RX_FIFO_EN` undefined, only 0x01 is retained.
- TX: pulse `tx_valid` one cycle with 8'hA5. Required: `uart_tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each bit for 8 cycles. `tx_ready` low for 80 cycles. Asserting `btn` mid-frame forces `uart_tx`=1 and `tx_ready`=1 immediately.
